seg7_capture_32: RTL

Receive-side counterpart of the 8-digit multiplexed seven-segment driver. It watches the active-low anode and cathode lines of the display bus and waits for each digit pattern to settle. Each settled digit is decoded back to its hex nibble and the 32-bit word is rebuilt. It sits beside the display driver for on-chip readback and self-check, and serves as the scoreboard front-end in display-path benches.

---
 rtl/seg7_capture_32.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seg7_capture_32.sv
// Display-bus readback. Waits for each anode/cathode pattern to settle, decodes it to a hex nibble,
// and rebuilds the 32-bit word shown on an 8-digit multiplexed seven-segment display.
module seg7_capture_32 #(
   parameter int SETTLE_CLOCKS = 4
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic [7:0]  an_i,
   input  logic        ca_i,
   input  logic        cb_i,
   input  logic        cc_i,
   input  logic        cd_i,
   input  logic        ce_i,
   input  logic        cf_i,
   input  logic        cg_i,
   output logic [31:0] data_o,
   output logic        valid_o,
   output logic        err_o,
   output logic [7:0]  seen_o
);

   localparam int CW = (SETTLE_CLOCKS > 0) ? $clog2(SETTLE_CLOCKS + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CLOCKS);
   localparam logic [CW-1:0] CNT_PRE = CW'(SETTLE_CLOCKS - 1);

   logic [14:0]   sample_in;
   logic [14:0]   sample_q;
   logic [CW-1:0] stable_cnt;
   logic          same;
   logic          capture;
   logic          complete;

   logic [31:0]   shadow, shadow_next;
   logic [7:0]    seen, seen_next;
   logic          frame_err, frame_err_next;

   logic [7:0]    an_q;
   logic [6:0]    seg_q;
   logic [2:0]    digit_k;
   logic [4:0]    dec;

   // Returns {valid, nibble}; cathodes are active-low, ordered {ca..cg}.
   function automatic logic [4:0] seg_decode(input logic [6:0] seg);
      case (seg)
         7'b0000001: return {1'b1, 4'h0};
         7'b1001111: return {1'b1, 4'h1};
         7'b0010010: return {1'b1, 4'h2};
         7'b0000110: return {1'b1, 4'h3};
         7'b1001100: return {1'b1, 4'h4};
         7'b0100100: return {1'b1, 4'h5};
         7'b0100000: return {1'b1, 4'h6};
         7'b0001111: return {1'b1, 4'h7};
         7'b0000000: return {1'b1, 4'h8};
         7'b0000100: return {1'b1, 4'h9};
         7'b0001000: return {1'b1, 4'hA};
         7'b1100000: return {1'b1, 4'hB};
         7'b0110001: return {1'b1, 4'hC};
         7'b1000010: return {1'b1, 4'hD};
         7'b0110000: return {1'b1, 4'hE};
         7'b0111000: return {1'b1, 4'hF};
         default:    return 5'b0;
      endcase
   endfunction

   assign sample_in = {an_i, ca_i, cb_i, cc_i, cd_i, ce_i, cf_i, cg_i};
   assign same      = (sample_in == sample_q);
   // Fires once per stable period: only the step from SETTLE-1 to SETTLE captures.
   assign capture   = same && (stable_cnt == CNT_PRE);
   assign an_q      = sample_q[14:7];
   assign seg_q     = sample_q[6:0];

   always_comb begin
      shadow_next    = shadow;
      seen_next      = seen;
      frame_err_next = frame_err;
      digit_k        = '0;
      dec            = seg_decode(seg_q);
      for (int i = 0; i < 8; i++) begin
         if (!an_q[i]) digit_k = 3'(i);
      end
      if (capture && (an_q != 8'hFF)) begin
         if ($onehot(~an_q)) begin
            seen_next[digit_k] = 1'b1;
            if (dec[4]) shadow_next[{digit_k, 2'b00} +: 4] = dec[3:0];
            else        frame_err_next = 1'b1;
         end else begin
            frame_err_next = 1'b1;
         end
      end
   end

   assign complete = capture && (seen_next == 8'hFF);

   always_ff @(posedge clk) begin
      if (rst_i) begin
         sample_q   <= '1;
         stable_cnt <= '0;
         shadow     <= '0;
         seen       <= '0;
         frame_err  <= 1'b0;
         data_o     <= '0;
         valid_o    <= 1'b0;
         err_o      <= 1'b0;
      end else begin
         sample_q <= sample_in;
         if (!same)                  stable_cnt <= '0;
         else if (stable_cnt != CNT_MAX) stable_cnt <= stable_cnt + 1'b1;
         shadow  <= shadow_next;
         valid_o <= complete;
         if (complete) begin
            data_o    <= shadow_next;
            err_o     <= frame_err_next;
            seen      <= '0;
            frame_err <= 1'b0;
         end else begin
            seen      <= seen_next;
            frame_err <= frame_err_next;
         end
      end
   end

   assign seen_o = seen;

endmodule
